// File: rtl/status_link_scheduler.sv
// rtl/status_link_scheduler.sv - fixed-priority scheduler and serialiser for the alarm-to-keyboard status link
//
// Three message sources share one serial link: alarm event (evt, highest priority),
// sensor change (sns), and periodic refresh (lowest). Each source keeps one pending
// flag and one message register, so a repeated request overwrites the older one.
// Each frame is LOAD (1 cycle), then SHIFT (MSG_W cycles, MSB first), then GAP
// (GAP_CYCLES cycles), then at least one IDLE cycle.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   evt_req / evt_msg     alarm state-change request pulse and its message
//   sns_req / sns_msg     sensor-change request pulse and its message
//   refresh_msg           status word, sampled when a refresh frame is loaded
//   evt_ack / sns_ack     one-cycle pulse during the LOAD cycle of that source's frame
//   status_send           high for exactly MSG_W cycles per frame
//   status_out            serial data, valid while status_send is high
//   busy                  high in LOAD, SHIFT and GAP
module status_link_scheduler #(
    parameter int MSG_W          = 4,
    parameter int GAP_CYCLES     = 2,
    parameter int REFRESH_CYCLES = 150000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             evt_req,
    input  logic [MSG_W-1:0] evt_msg,
    input  logic             sns_req,
    input  logic [MSG_W-1:0] sns_msg,
    input  logic [MSG_W-1:0] refresh_msg,
    output logic             evt_ack,
    output logic             sns_ack,
    output logic             status_send,
    output logic             status_out,
    output logic             busy
);

    localparam int CNT_MAX = (MSG_W > GAP_CYCLES) ? MSG_W : GAP_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int RW      = $clog2(REFRESH_CYCLES);

    localparam logic [CW-1:0] SHIFT_LAST = CW'(MSG_W - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);
    localparam logic [RW-1:0] REF_LAST   = RW'(REFRESH_CYCLES - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT, ST_GAP} state_t;
    typedef enum logic [1:0] {SRC_EVT, SRC_SNS, SRC_REF} src_t;

    state_t           state_q, state_d;
    src_t             win_q, win_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [MSG_W-1:0] shift_q, shift_d;
    logic             evt_pend_q, evt_pend_d;
    logic             sns_pend_q, sns_pend_d;
    logic             ref_pend_q, ref_pend_d;
    logic [MSG_W-1:0] evt_msg_q, evt_msg_d;
    logic [MSG_W-1:0] sns_msg_q, sns_msg_d;
    logic [RW-1:0]    ref_cnt_q, ref_cnt_d;
    logic             evt_ack_q, evt_ack_d;
    logic             sns_ack_q, sns_ack_d;
    logic             send_q, send_d;
    logic             busy_q, busy_d;

    always_comb begin
        state_d    = state_q;
        win_d      = win_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        evt_pend_d = evt_pend_q;
        sns_pend_d = sns_pend_q;
        ref_pend_d = ref_pend_q;
        evt_msg_d  = evt_msg_q;
        sns_msg_d  = sns_msg_q;
        ref_cnt_d  = ref_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (evt_pend_q) begin
                    state_d = ST_LOAD;
                    win_d   = SRC_EVT;
                end else if (sns_pend_q) begin
                    state_d = ST_LOAD;
                    win_d   = SRC_SNS;
                end else if (ref_pend_q) begin
                    state_d = ST_LOAD;
                    win_d   = SRC_REF;
                end
            end
            ST_LOAD: begin
                state_d = ST_SHIFT;
                cnt_d   = '0;
                case (win_q)
                    SRC_EVT: begin
                        shift_d    = evt_msg_q;
                        evt_pend_d = 1'b0;
                    end
                    SRC_SNS: begin
                        shift_d    = sns_msg_q;
                        sns_pend_d = 1'b0;
                    end
                    default: begin
                        shift_d    = refresh_msg;
                        ref_pend_d = 1'b0;
                    end
                endcase
            end
            ST_SHIFT: begin
                // Zero fill means the register is empty once the frame ends,
                // which keeps status_out low outside frames.
                shift_d = shift_q << 1;
                if (cnt_q == SHIFT_LAST) begin
                    state_d = ST_GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A request is applied after the LOAD clear: a request on the LOAD cycle
        // re-arms the source for a second frame.
        if (evt_req) begin
            evt_pend_d = 1'b1;
            evt_msg_d  = evt_msg;
        end
        if (sns_req) begin
            sns_pend_d = 1'b1;
            sns_msg_d  = sns_msg;
        end

        // The refresh timer restarts on every frame load, whatever the source.
        if (state_q == ST_IDLE && state_d == ST_LOAD) begin
            ref_cnt_d = '0;
        end else if (ref_cnt_q != REF_LAST) begin
            ref_cnt_d = ref_cnt_q + 1'b1;
        end
        if (ref_cnt_d == REF_LAST) begin
            ref_pend_d = 1'b1;
        end

        evt_ack_d = (state_d == ST_LOAD) && (win_d == SRC_EVT);
        sns_ack_d = (state_d == ST_LOAD) && (win_d == SRC_SNS);
        send_d    = (state_d == ST_SHIFT);
        busy_d    = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            win_q      <= SRC_EVT;
            cnt_q      <= '0;
            shift_q    <= '0;
            evt_pend_q <= 1'b0;
            sns_pend_q <= 1'b0;
            ref_pend_q <= 1'b0;
            evt_msg_q  <= '0;
            sns_msg_q  <= '0;
            ref_cnt_q  <= '0;
            evt_ack_q  <= 1'b0;
            sns_ack_q  <= 1'b0;
            send_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            evt_pend_q <= evt_pend_d;
            sns_pend_q <= sns_pend_d;
            ref_pend_q <= ref_pend_d;
            evt_msg_q  <= evt_msg_d;
            sns_msg_q  <= sns_msg_d;
            ref_cnt_q  <= ref_cnt_d;
            evt_ack_q  <= evt_ack_d;
            sns_ack_q  <= sns_ack_d;
            send_q     <= send_d;
            busy_q     <= busy_d;
        end
    end

    assign evt_ack     = evt_ack_q;
    assign sns_ack     = sns_ack_q;
    assign status_send = send_q;
    assign status_out  = shift_q[MSG_W-1];
    assign busy        = busy_q;

endmodule

// File: tb/tb_status_link_scheduler.sv
// tb/tb_status_link_scheduler.sv - self-checking bench for status_link_scheduler
module tb_status_link_scheduler;

    localparam int W = 4;
    localparam int G = 2;
    localparam int R = 20;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         evt_req = 1'b0;
    logic [W-1:0] evt_msg = '0;
    logic         sns_req = 1'b0;
    logic [W-1:0] sns_msg = '0;
    logic [W-1:0] refresh_msg = '0;
    logic         evt_ack, sns_ack, status_send, status_out, busy;

    always #5 clk = ~clk;

    status_link_scheduler #(
        .MSG_W(W), .GAP_CYCLES(G), .REFRESH_CYCLES(R)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .evt_req(evt_req), .evt_msg(evt_msg),
        .sns_req(sns_req), .sns_msg(sns_msg),
        .refresh_msg(refresh_msg),
        .evt_ack(evt_ack), .sns_ack(sns_ack),
        .status_send(status_send), .status_out(status_out), .busy(busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a timeline of frames. A frame is identified by the edge
    // at which LOAD begins; every output is derived from the distance to it.
    int           t      = 0;
    int           load_t = -1000;
    int           lref   = 0;
    int           src    = 0;
    bit           pend[3];
    logic [W-1:0] pmsg[2];
    logic [W-1:0] fmsg   = '0;

    task automatic model_edge();
        bit pre[3];
        t++;
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) pend[i] = 1'b0;
            pmsg[0] = '0;
            pmsg[1] = '0;
            load_t  = -1000;
            lref    = t;
            return;
        end
        pre = pend;
        if (t == load_t + 1) begin
            fmsg = (src == 2) ? refresh_msg : pmsg[src];
            pend[src] = 1'b0;
        end
        if (evt_req) begin pend[0] = 1'b1; pmsg[0] = evt_msg; end
        if (sns_req) begin pend[1] = 1'b1; pmsg[1] = sns_msg; end
        if ((t - 1 >= load_t + W + G + 1) && (pre[0] || pre[1] || pre[2])) begin
            load_t = t;
            lref   = t;
            src    = pre[0] ? 0 : (pre[1] ? 1 : 2);
        end
        if (t - lref == R - 1) pend[2] = 1'b1;
    endtask

    task automatic check_model();
        int   ph;
        logic e_send, e_out;
        ph     = t - load_t;
        e_send = (ph >= 1) && (ph <= W);
        e_out  = e_send ? fmsg[W-ph] : 1'b0;
        chk("m_evt_ack", evt_ack, (ph == 0) && (src == 0));
        chk("m_sns_ack", sns_ack, (ph == 0) && (src == 1));
        chk("m_status_send", status_send, e_send);
        chk("m_status_out", status_out, e_out);
        chk("m_busy", busy, (ph >= 0) && (ph <= W + G));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_model();
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        evt_req = 1'b0;
        sns_req = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic         er;
        logic [W-1:0] em;
        logic         sr;
        logic [W-1:0] sm;
        logic         send, out, ack_e, ack_s, bsy;
    } vec_t;

    vec_t tbl[9];

    initial begin
        int           fb, nsend, a1, a2, ea, sa, dual, nsa;
        logic [W-1:0] bits;

        //           er  em       sr  sm     send out ack_e ack_s busy
        tbl[0] = '{1'b1, 4'b0110, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 4'h0,    1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[2] = '{1'b0, 4'h0,    1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[3] = '{1'b0, 4'h0,    1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[4] = '{1'b0, 4'h0,    1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[5] = '{1'b0, 4'h0,    1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[6] = '{1'b0, 4'h0,    1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[7] = '{1'b0, 4'h0,    1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[8] = '{1'b0, 4'h0,    1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        refresh_msg = 4'b1010;
        do_reset();
        chk("reset_send", status_send, 1'b0);
        chk("reset_out", status_out, 1'b0);
        chk("reset_evt_ack", evt_ack, 1'b0);
        chk("reset_sns_ack", sns_ack, 1'b0);
        chk("reset_busy", busy, 1'b0);

        // Idle until the first refresh frame.
        fb = 0; nsend = 0; bits = '0;
        for (int i = 1; i <= 27; i++) begin
            step();
            if (busy && fb == 0) fb = i;
            if (status_send) begin bits = {bits[W-2:0], status_out}; nsend++; end
        end
        chk("refresh_load_cycle", fb, 20);
        chk("refresh_bits", bits, 4'b1010);
        chk("refresh_send_len", nsend, 4);

        // Single evt frame, cycle by cycle from the table.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            evt_req = tbl[i].er; evt_msg = tbl[i].em;
            sns_req = tbl[i].sr; sns_msg = tbl[i].sm;
            step();
            chk($sformatf("tbl%0d_send", i), status_send, tbl[i].send);
            chk($sformatf("tbl%0d_out", i), status_out, tbl[i].out);
            chk($sformatf("tbl%0d_evt_ack", i), evt_ack, tbl[i].ack_e);
            chk($sformatf("tbl%0d_sns_ack", i), sns_ack, tbl[i].ack_s);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].bsy);
        end
        evt_req = 1'b0;

        // Simultaneous evt and sns: evt first, sns LOAD 8 cycles later.
        do_reset();
        evt_req = 1'b1; evt_msg = 4'b1000; sns_req = 1'b1; sns_msg = 4'b0001;
        step();
        evt_req = 1'b0; sns_req = 1'b0;
        ea = -1; sa = -1; dual = 0; bits = '0;
        for (int i = 1; i <= 18; i++) begin
            step();
            if (evt_ack && sns_ack) dual++;
            if (evt_ack && ea < 0) ea = i;
            if (sns_ack && sa < 0) sa = i;
            if (status_send && sa >= 0) bits = {bits[W-2:0], status_out};
        end
        chk("prio_evt_ack_cycle", ea, 1);
        chk("prio_sns_gap", sa - ea, W + G + 2);
        chk("prio_dual_ack", dual, 0);
        chk("prio_sns_bits", bits, 4'b0001);

        // Two sns requests during an evt frame coalesce into one sns frame.
        do_reset();
        evt_req = 1'b1; evt_msg = 4'b0101;
        step();
        evt_req = 1'b0;
        nsa = 0; nsend = 0; bits = '0; sa = -1;
        for (int i = 1; i <= 20; i++) begin
            sns_req = (i == 3) || (i == 5);
            sns_msg = (i == 3) ? 4'b0011 : 4'b1100;
            step();
            if (sns_ack) begin nsa++; sa = i; end
            if (status_send) nsend++;
            if (status_send && sa >= 0) bits = {bits[W-2:0], status_out};
        end
        sns_req = 1'b0;
        chk("coal_sns_ack_count", nsa, 1);
        chk("coal_sns_bits", bits, 4'b1100);
        chk("coal_send_total", nsend, 2 * W);

        // New evt request on the evt LOAD cycle yields a back-to-back second frame.
        do_reset();
        evt_req = 1'b1; evt_msg = 4'b0110;
        step();
        evt_req = 1'b0;
        step();
        chk("rereq_first_ack", evt_ack, 1'b1);
        evt_req = 1'b1; evt_msg = 4'b1111;
        a1 = 0; a2 = -1; bits = '0;
        for (int i = 1; i <= 16; i++) begin
            step();
            evt_req = 1'b0;
            if (evt_ack && a2 < 0) a2 = i;
            if (status_send && a2 >= 0) bits = {bits[W-2:0], status_out};
        end
        chk("rereq_second_gap", a2 - a1, W + G + 2);
        chk("rereq_bits", bits, 4'b1111);

        // Asynchronous reset during the second shift bit.
        do_reset();
        evt_req = 1'b1; evt_msg = 4'b1001;
        step();
        evt_req = 1'b0;
        step();
        step();
        step();
        chk("midrst_pre_send", status_send, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_send", status_send, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_out", status_out, 1'b0);
        step();
        step();
        rst_n = 1'b1;
        fb = 0;
        for (int i = 1; i <= 19; i++) begin
            step();
            if (busy || status_send) fb++;
        end
        chk("midrst_no_resend", fb, 0);

        // Randomised traffic with occasional resets, checked against the model.
        for (int i = 0; i < 1500; i++) begin
            evt_req     = ($urandom_range(0, 11) == 0);
            evt_msg     = W'($urandom);
            sns_req     = ($urandom_range(0, 9) == 0);
            sns_msg     = W'($urandom);
            refresh_msg = W'($urandom);
            rst_n       = ($urandom_range(0, 399) != 0);
            step();
        end
        rst_n = 1'b1; evt_req = 1'b0; sns_req = 1'b0;
        for (int i = 0; i < 10; i++) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
